instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch stage: owns the program counter, issues word requests to instruction memory over a req/ready handshake, and drives the PC/instruction pair consumed by the IF/ID pipeline buffer. Supports pipeline stall from hazard logic and branch/jump redirect with squash of in-flight or held fetches. All state updates on the rising edge of `clock`, so outputs are stable when the IF/ID buffer samples on the falling edge.

## Interface
- `PC_WIDTH`, 32, width of all PC/address values
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `PC_STEP`, 1, increment per sequential fetch (word-addressed memory)
- `NOP`, 32'h0000_0000, instruction word driven during bubbles

- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold outputs and PC; no new request issued
- `branch_taken`  in  1  single-cycle redirect request
- `branch_target`  in  PC_WIDTH  redirect address, used as-is
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  PC_WIDTH  fetch address
- `imem_ready`  in  1  `imem_data` valid this cycle for the current request
- `imem_data`  in  32  fetched instruction word
- `PC`  out  PC_WIDTH  address of `instruction`, to IF/ID buffer
- `instruction`  out  32  fetched word, to IF/ID buffer
- `valid`  out  1  high when `PC`/`instruction` form a real instruction

## Operation
- Internal: `pc` (next fetch address), `held_pc`/`held_data` (skid register), `squash` flag, state in {FETCH, WAIT, HOLD}.
- `imem_addr` = `pc` always. `imem_req` = (FETCH & !stall) | WAIT. Combinational from registered state.
- Handshake accepted when `imem_req & imem_ready`. Once `imem_req` is high without ready, `imem_req` and `imem_addr` stay stable until accepted, regardless of `stall`.
- FETCH:
  - `branch_taken`: `pc`<=`branch_target`, outputs<=bubble (`valid`=0, `instruction`=NOP), stay FETCH. Any same-cycle accepted data is discarded.
  - else `stall`: no request, outputs and `pc` hold.
  - else accepted: `PC`<=`pc`, `instruction`<=`imem_data`, `valid`<=1, `pc`<=`pc`+`PC_STEP`.
  - else (req, no ready): -> WAIT.
- WAIT:
  - `branch_taken`: `pc`<=`branch_target`, outputs<=bubble, `squash`<=1.
  - on ready: if `squash` (or `branch_taken` this cycle): drop data, clear `squash`, -> FETCH. Else if `stall`: `held_pc`<=`pc`, `held_data`<=`imem_data`, `pc`<=`pc`+`PC_STEP`, -> HOLD. Else deliver as in FETCH, -> FETCH.
- HOLD (no request):
  - `branch_taken`: discard held word, `pc`<=`branch_target`, outputs<=bubble, -> FETCH.
  - `stall` low: outputs<=held pair, `valid`<=1, -> FETCH.
- Priority: reset > `branch_taken` > `stall` > sequential fetch. Branch flushes outputs even while stalled.
- Arithmetic: `pc`+`PC_STEP` modulo 2^PC_WIDTH; wraps silently at all-ones.

## Timing
- Reset (async, immediate): `pc`=RESET_PC, state=FETCH, `PC`=0, `instruction`=NOP, `valid`=0, `squash`=0, held regs=0. `imem_req` rises combinationally once `reset_n` deasserts (if `stall`=0).
- Reset mid-WAIT: request abandoned immediately; memory must tolerate dropped `imem_req`.
- Zero-wait memory (`imem_ready` tied high): one instruction per cycle. Address X issued in cycle n appears on `PC`/`instruction` after edge n.
- Redirect latency: `branch_taken` in cycle n -> bubble after edge n; target address issued in cycle n+1 (FETCH/HOLD) or after squashed response returns (WAIT); target instruction visible one accepted handshake later.
- `stall` rising: outputs frozen from the next edge; no instruction lost or duplicated across any stall/ready interleaving.

## Test plan
- Reset, `imem_ready`=1, mem[i]=i+0x100: `PC`=0,1,2,3 with `instruction`=0x100..0x103, `valid`=1 on consecutive edges.
- `stall` high cycles 3-5: outputs hold `PC`=2, `imem_req`=0; release -> `PC`=3 next, no gap or repeat.
- Ready delayed 3 cycles at addr 4 with `stall` rising during wait: req/addr stable, word parked in HOLD, delivered as `PC`=4 the cycle after `stall` drops.
- `branch_taken` to 0x40 while in WAIT at addr 7: bubble (`valid`=0, NOP), late addr-7 data dropped, next delivered `PC`=0x40.
- `branch_taken` with `stall` high in HOLD: held word discarded, bubble, fetch resumes at target.
- `pc` preset near 0xFFFF_FFFF via branch: sequence 0xFFFF_FFFF then 0x0000_0000; reset asserted mid-WAIT -> `imem_req`=0 and all outputs at reset values immediately.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ready handshake,
// and presents PC/instruction/valid to the IF/ID buffer with stall and redirect support.
module instruction_fetch #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [PC_WIDTH-1:0] PC_STEP  = 1,
  parameter logic [31:0]         NOP      = 32'h0000_0000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_data,
  output logic [PC_WIDTH-1:0] PC,
  output logic [31:0]         instruction,
  output logic                valid,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic [PC_WIDTH-1:0] held_pc, held_pc_nxt;
  logic [31:0]         held_data, held_data_nxt;
  logic                squash, squash_nxt;
  logic [PC_WIDTH-1:0] pc_out_nxt;
  logic [31:0]         instr_nxt;
  logic                valid_nxt;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                req_int;

  // Handshake: a word transfers on any cycle where imem_req & imem_ready. Once
  // imem_req is raised without ready, it and imem_addr stay put until accepted;
  // only a redirect (which squashes the response) or reset may alter them.
  assign req_int   = ((state == S_FETCH) && !stall) || (state == S_WAIT);
  assign imem_req  = reset_n & req_int;
  assign imem_addr = pc;
  assign pc_inc    = pc + PC_STEP;
  assign fsm_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      held_pc     <= '0;
      held_data   <= '0;
      squash      <= 1'b0;
      PC          <= '0;
      instruction <= NOP;
      valid       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      held_pc     <= held_pc_nxt;
      held_data   <= held_data_nxt;
      squash      <= squash_nxt;
      PC          <= pc_out_nxt;
      instruction <= instr_nxt;
      valid       <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    held_pc_nxt   = held_pc;
    held_data_nxt = held_data;
    squash_nxt    = squash;
    pc_out_nxt    = PC;
    instr_nxt     = instruction;
    valid_nxt     = valid;

    case (state)
      S_FETCH: begin
        if (branch_taken) begin
          pc_nxt    = branch_target;
          instr_nxt = NOP;
          valid_nxt = 1'b0;
        end else if (stall) begin
          state_nxt = S_FETCH;
        end else if (imem_ready) begin
          pc_out_nxt = pc;
          instr_nxt  = imem_data;
          valid_nxt  = 1'b1;
          pc_nxt     = pc_inc;
        end else begin
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (branch_taken) begin
          pc_nxt    = branch_target;
          instr_nxt = NOP;
          valid_nxt = 1'b0;
          // A response arriving in the redirect cycle is dropped right away;
          // otherwise remember to drop the one still on its way.
          squash_nxt = !imem_ready;
          if (imem_ready) state_nxt = S_FETCH;
        end else if (imem_ready) begin
          state_nxt = S_FETCH;
          if (squash) begin
            squash_nxt = 1'b0;
          end else if (stall) begin
            held_pc_nxt   = pc;
            held_data_nxt = imem_data;
            pc_nxt        = pc_inc;
            state_nxt     = S_HOLD;
          end else begin
            pc_out_nxt = pc;
            instr_nxt  = imem_data;
            valid_nxt  = 1'b1;
            pc_nxt     = pc_inc;
          end
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          pc_nxt    = branch_target;
          instr_nxt = NOP;
          valid_nxt = 1'b0;
          state_nxt = S_FETCH;
        end else if (!stall) begin
          pc_out_nxt = held_pc;
          instr_nxt  = held_data;
          valid_nxt  = 1'b1;
          state_nxt  = S_FETCH;
        end
      end

      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed cycle table for the scripted scenarios,
// a reset-mid-wait sequence, then random traffic against a stream-level model.
module tb_instruction_fetch;
  localparam int W = 32;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;
  localparam logic [31:0] NOP_W = 32'h0000_0000;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         stall = 1'b0;
  logic         branch_taken = 1'b0;
  logic [W-1:0] branch_target = '0;
  logic         imem_ready = 1'b0;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic [31:0]  imem_data;
  logic [W-1:0] pc_o;
  logic [31:0]  instruction;
  logic         valid;
  logic [1:0]   fsm_state;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(
    .PC_WIDTH(W), .RESET_PC(32'h0000_0000), .PC_STEP(32'h1), .NOP(NOP_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .PC(pc_o), .instruction(instruction), .valid(valid),
    .fsm_state(fsm_state)
  );

  // clock / memory
  always #5 clock = ~clock;
  assign imem_data = imem_addr + 32'h100;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        v;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                              input logic r, input logic q, input logic [31:0] a,
                              input logic [31:0] p, input logic [31:0] n, input logic v);
    vec_t x;
    x.stall = s; x.br = b; x.tgt = t; x.rdy = r;
    x.req = q; x.addr = a; x.pc = p; x.ins = n; x.v = v;
    return x;
  endfunction

  // scoreboard / reference model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] next_addr;
  logic         outstanding;
  logic         dirty;
  logic [W-1:0] exp_pc;
  logic [31:0]  exp_ins;
  logic         exp_v;

  initial begin
    // expected table: inputs in cycle k, req/addr before edge k, outputs after edge k
    vecs[0]  = mk(L, L, 0, H,  H, 32'h0,  32'h0, 32'h100, H);
    vecs[1]  = mk(L, L, 0, H,  H, 32'h1,  32'h1, 32'h101, H);
    vecs[2]  = mk(L, L, 0, H,  H, 32'h2,  32'h2, 32'h102, H);
    vecs[3]  = mk(H, L, 0, H,  L, 32'h3,  32'h2, 32'h102, H);
    vecs[4]  = mk(H, L, 0, H,  L, 32'h3,  32'h2, 32'h102, H);
    vecs[5]  = mk(H, L, 0, H,  L, 32'h3,  32'h2, 32'h102, H);
    vecs[6]  = mk(L, L, 0, H,  H, 32'h3,  32'h3, 32'h103, H);
    vecs[7]  = mk(L, L, 0, L,  H, 32'h4,  32'h3, 32'h103, H);
    vecs[8]  = mk(H, L, 0, L,  H, 32'h4,  32'h3, 32'h103, H);
    vecs[9]  = mk(H, L, 0, L,  H, 32'h4,  32'h3, 32'h103, H);
    vecs[10] = mk(H, L, 0, H,  H, 32'h4,  32'h3, 32'h103, H);
    vecs[11] = mk(H, L, 0, H,  L, 32'h5,  32'h3, 32'h103, H);
    vecs[12] = mk(L, L, 0, H,  L, 32'h5,  32'h4, 32'h104, H);
    vecs[13] = mk(L, L, 0, H,  H, 32'h5,  32'h5, 32'h105, H);
    vecs[14] = mk(L, L, 0, H,  H, 32'h6,  32'h6, 32'h106, H);
    vecs[15] = mk(L, L, 0, L,  H, 32'h7,  32'h6, 32'h106, H);
    vecs[16] = mk(L, H, 32'h40, L, H, 32'h7, 32'h0, NOP_W, L);
    vecs[17] = mk(L, L, 0, H,  H, 32'h40, 32'h0, NOP_W, L);
    vecs[18] = mk(L, L, 0, H,  H, 32'h40, 32'h40, 32'h140, H);
    vecs[19] = mk(L, L, 0, H,  H, 32'h41, 32'h41, 32'h141, H);
    vecs[20] = mk(L, L, 0, L,  H, 32'h42, 32'h41, 32'h141, H);
    vecs[21] = mk(H, L, 0, H,  H, 32'h42, 32'h41, 32'h141, H);
    vecs[22] = mk(H, H, 32'h80, L, L, 32'h43, 32'h0, NOP_W, L);
    vecs[23] = mk(H, L, 0, H,  L, 32'h80, 32'h0, NOP_W, L);
    vecs[24] = mk(L, L, 0, H,  H, 32'h80, 32'h80, 32'h180, H);
    vecs[25] = mk(L, H, 32'hFFFF_FFFE, H, H, 32'h81, 32'h0, NOP_W, L);
    vecs[26] = mk(L, L, 0, H,  H, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0000_00FE, H);
    vecs[27] = mk(L, L, 0, H,  H, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF, H);
    vecs[28] = mk(L, L, 0, H,  H, 32'h0,  32'h0, 32'h100, H);
    vecs[29] = mk(L, L, 0, H,  H, 32'h1,  32'h1, 32'h101, H);
    vecs[30] = mk(L, L, 0, L,  H, 32'h2,  32'h1, 32'h101, H);
    vecs[31] = mk(L, L, 0, L,  H, 32'h2,  32'h1, 32'h101, H);

    // reset state
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check1("rst_req", imem_req, 1'b0);
    check32("rst_addr", imem_addr, 32'h0);
    check32("rst_pc", pc_o, 32'h0);
    check32("rst_instr", instruction, NOP_W);
    check1("rst_valid", valid, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // directed table
    for (int i = 0; i < NV; i++) begin
      stall = vecs[i].stall;
      branch_taken = vecs[i].br;
      branch_target = vecs[i].tgt;
      imem_ready = vecs[i].rdy;
      #1;
      check1($sformatf("vec%0d_req", i), imem_req, vecs[i].req);
      check32($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      @(posedge clock);
      #1;
      check1($sformatf("vec%0d_valid", i), valid, vecs[i].v);
      check32($sformatf("vec%0d_instr", i), instruction, vecs[i].ins);
      if (vecs[i].v) check32($sformatf("vec%0d_pc", i), pc_o, vecs[i].pc);
      @(negedge clock);
    end

    // reset asserted while a fetch is waiting: everything drops immediately
    reset_n = 1'b0;
    #1;
    check1("midwait_rst_req", imem_req, 1'b0);
    check32("midwait_rst_addr", imem_addr, 32'h0);
    check32("midwait_rst_pc", pc_o, 32'h0);
    check32("midwait_rst_instr", instruction, NOP_W);
    check1("midwait_rst_valid", valid, 1'b0);
    stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check1("post_rst_req", imem_req, 1'b1);
    check32("post_rst_addr", imem_addr, 32'h0);

    // random traffic against a stream model: every accepted, unsquashed word
    // must emerge exactly once, in address order, as soon as stall allows
    exp_q.delete();
    next_addr = 32'h0;
    outstanding = 1'b0;
    dirty = 1'b0;
    exp_pc = 32'h0;
    exp_ins = NOP_W;
    exp_v = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic exp_req, acc, squashed;
      logic [W-1:0] a;
      stall = ($urandom_range(0, 99) < 30);
      branch_taken = ($urandom_range(0, 99) < 10);
      branch_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 3)) : $urandom;
      imem_ready = ($urandom_range(0, 99) < 60);
      #1;
      exp_req = outstanding || (!stall && exp_q.size() == 0);
      check1("rnd_req", imem_req, exp_req);
      if (exp_req) check32("rnd_addr", imem_addr, next_addr);
      acc = exp_req && imem_ready;
      squashed = branch_taken || dirty;
      if (acc) begin
        if (!squashed) begin
          exp_q.push_back(next_addr);
          next_addr = next_addr + 32'h1;
        end
        outstanding = 1'b0;
        dirty = 1'b0;
      end else if (exp_req) begin
        if (outstanding) begin
          if (branch_taken) dirty = 1'b1;
        end else if (!branch_taken) begin
          outstanding = 1'b1;
        end
      end
      if (branch_taken) begin
        exp_q.delete();
        next_addr = branch_target;
        exp_v = 1'b0;
        exp_ins = NOP_W;
      end else if (!stall && exp_q.size() > 0) begin
        a = exp_q.pop_front();
        exp_pc = a;
        exp_ins = a + 32'h100;
        exp_v = 1'b1;
      end
      @(posedge clock);
      #1;
      check1("rnd_valid", valid, exp_v);
      check32("rnd_instr", instruction, exp_ins);
      if (exp_v) check32("rnd_pc", pc_o, exp_pc);
      @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
